// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
// Control sequencer for a single DSP48A1 slice running multiply-accumulate
// bursts. A burst length is taken with start; operand pairs are then accepted
// over a valid/ready handshake while the A/B, M and P clock enables and the
// accumulate-select bit are driven so that P ends up holding the burst's sum
// of products. done pulses at the edge where the final product lands in P.
//
// Ports:
//   CLK        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a burst (sampled only in IDLE)
//   len        in   burst length in operand pairs (sampled with start)
//   op_valid   in   operand pair present on the slice A/B inputs
//   op_ready   out  pair is accepted this cycle if op_valid
//   CE_AB      out  A/B input register enable (equals the accept strobe)
//   CE_M       out  M register enable
//   CE_P       out  P register enable
//   OPMODE_ACC out  0: P = M, 1: P = P + M
//   busy       out  burst in progress (RUN or DRAIN)
//   done       out  one-cycle pulse, final product is in P
//   err        out  one-cycle pulse on a len=0 start or a watchdog abort
//
// Configuration macro:
//   MAC_SEQ_TIMEOUT_EN  compiles in the RUN idle watchdog (TIMEOUT cycles).
// -----------------------------------------------------------------------------
module dsp_mac_sequencer #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic                 CE_AB,
  output logic                 CE_M,
  output logic                 CE_P,
  output logic                 OPMODE_ACC,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_pcnt;
  logic                 r_first;
  logic                 r_tok0_v;
  logic                 r_tok0_f;
  logic                 r_tok1_v;
  logic                 r_tok1_f;
  logic                 r_op_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic w_accept;
  logic w_last_accept;
  logic w_last_p;
  logic w_abort;

  assign w_accept      = op_valid & r_op_ready;
  assign w_last_accept = w_accept && (r_remaining == CNT_WIDTH'(1));
  // P update for the len-th token of the burst
  assign w_last_p      = r_tok1_v && (r_pcnt == (r_len - CNT_WIDTH'(1)));

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] r_idle;

  // Consecutive RUN cycles without an accept
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_idle <= '0;
    end else if ((r_state != S_RUN) || w_accept) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  // Abort on the edge where the idle count would reach TIMEOUT
  assign w_abort = (r_state == S_RUN) && !w_accept &&
                   (r_idle == IDLE_W'(TIMEOUT - 1));
`else
  // Watchdog absent: RUN waits forever; TIMEOUT only appears as a constant
  assign w_abort = 1'b0 & (TIMEOUT == 0);
`endif

  // Burst FSM, token pipeline and registered status outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_len       <= '0;
      r_pcnt      <= '0;
      r_first     <= 1'b0;
      r_tok0_v    <= 1'b0;
      r_tok0_f    <= 1'b0;
      r_tok1_v    <= 1'b0;
      r_tok1_f    <= 1'b0;
      r_op_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // Tokens advance every cycle; bubbles simply leave an empty slot
      r_tok1_v <= r_tok0_v;
      r_tok1_f <= r_tok0_f;
      r_tok0_v <= w_accept;
      r_tok0_f <= w_accept & r_first;

      if (w_accept) begin
        r_first     <= 1'b0;
        r_remaining <= r_remaining - CNT_WIDTH'(1);
      end

      if (r_tok1_v) begin
        r_pcnt <= r_pcnt + CNT_WIDTH'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_remaining <= len;
              r_len       <= len;
              r_pcnt      <= '0;
              r_first     <= 1'b1;
              r_op_ready  <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (w_last_accept) begin
            r_state    <= S_DRAIN;
            r_op_ready <= 1'b0;
          end else if (w_abort) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_tok0_v   <= 1'b0;
            r_tok0_f   <= 1'b0;
            r_tok1_v   <= 1'b0;
            r_tok1_f   <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (w_last_p) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready   = r_op_ready;
  assign CE_AB      = w_accept;
  assign CE_M       = r_tok0_v;
  assign CE_P       = r_tok1_v;
  assign OPMODE_ACC = r_tok1_v & ~r_tok1_f;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
